// File: rtl/mem_responder.sv
// Memory-side end of the MEM-stage transaction: drives a single-port SRAM with
// programmable wait states and tracks multi-word blocks to generate mem_force.
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [CNT_W-1:0]  req_cnt,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_force,
    output logic              busy,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [3:0]        wait_q, wait_d;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Block length is taken only on the first word; zero means one word.
                    if (rem_q == '0) begin
                        rem_d = (req_cnt == '0) ? CNT_W'(1) : req_cnt;
                    end
                    wait_d  = WAIT_INIT;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wait_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = sram_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rem_q   <= '0;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign mem_force  = (state_q == S_RESP) && (rem_q > CNT_W'(1));
    assign busy       = (state_q != S_IDLE) || (rem_q != '0);
    assign rsp_rdata  = rdata_q;
    assign sram_cs    = (state_q == S_ACCESS);
    assign sram_we    = (state_q == S_ACCESS) && we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=1 instance for function and
// block behaviour, plus WAIT_CYCLES=0 and 3 instances for latency and spacing.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_valid_w0, req_valid_w3;
    logic        req_we;
    logic [15:0] req_addr, req_wdata;
    logic [3:0]  req_cnt;

    logic        req_ready, rsp_valid, mem_force, busy, sram_cs, sram_we;
    logic [15:0] rsp_rdata, sram_addr, sram_wdata, sram_rdata;

    logic        ready_w0, rsp_w0, force_w0, busy_w0, cs_w0, we_w0;
    logic [15:0] rdata_w0, addr_w0, wdata_w0;
    logic        ready_w3, rsp_w3, force_w3, busy_w3, cs_w3, we_w3;
    logic [15:0] rdata_w3, addr_w3, wdata_w3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .CNT_W(4), .WAIT_CYCLES(1)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_cnt(req_cnt),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_force(mem_force), .busy(busy),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .CNT_W(4), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid_w0), .req_ready(ready_w0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_cnt(req_cnt),
        .rsp_valid(rsp_w0), .rsp_rdata(rdata_w0), .mem_force(force_w0), .busy(busy_w0),
        .sram_cs(cs_w0), .sram_we(we_w0), .sram_addr(addr_w0),
        .sram_wdata(wdata_w0), .sram_rdata(16'h0000)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .CNT_W(4), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid_w3), .req_ready(ready_w3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_cnt(req_cnt),
        .rsp_valid(rsp_w3), .rsp_rdata(rdata_w3), .mem_force(force_w3), .busy(busy_w3),
        .sram_cs(cs_w3), .sram_we(we_w3), .sram_addr(addr_w3),
        .sram_wdata(wdata_w3), .sram_rdata(16'h0000)
    );

    // Fixed-content read model and a write recorder for the main instance.
    always_comb begin
        case (sram_addr)
            16'h0010: sram_rdata = 16'hBEEF;
            16'h0040: sram_rdata = 16'hA0A0;
            16'h0041: sram_rdata = 16'hA1A1;
            16'h0042: sram_rdata = 16'hA2A2;
            16'h0043: sram_rdata = 16'hA3A3;
            default:  sram_rdata = 16'h5A5A;
        endcase
    end

    int          wr_count = 0;
    logic [15:0] wr_addr  = 16'h0000;
    logic [15:0] wr_data  = 16'h0000;
    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            wr_count <= wr_count + 1;
            wr_addr  <= sram_addr;
            wr_data  <= sram_wdata;
        end
    end

    int          obs_cs, obs_we, obs_rsp_k, obs_pulses;
    logic        obs_stable, obs_force, obs_busy_rsp, obs_busy_after, obs_ready_after, obs_rsp_after;
    logic [15:0] obs_rdata;

    // Issue one word to the main instance and record what happens until one cycle past the response.
    task automatic run_word(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [3:0] cnt, input logic hold);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_cnt   = cnt;
        @(posedge clk);
        obs_cs = 0; obs_we = 0; obs_rsp_k = 0; obs_pulses = 0; obs_stable = 1'b1;
        obs_force = 1'b0; obs_busy_rsp = 1'b0; obs_rdata = 16'h0000;
        for (int k = 1; k <= 12 && obs_rsp_k == 0; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (sram_cs) begin
                obs_cs++;
                if (sram_we) obs_we++;
                if (sram_addr !== addr || sram_wdata !== wdata) obs_stable = 1'b0;
            end
            if (rsp_valid) begin
                obs_pulses++;
                obs_rsp_k    = k;
                obs_rdata    = rsp_rdata;
                obs_force    = mem_force;
                obs_busy_rsp = busy;
            end
        end
        @(negedge clk);
        req_valid       = 1'b0;
        obs_busy_after  = busy;
        obs_ready_after = req_ready;
        obs_rsp_after   = rsp_valid;
        $display("word we=%0b addr=%h cnt=%0d: cs=%0d rsp@%0d rdata=%h force=%0b busy_after=%0b",
                 we, addr, cnt, obs_cs, obs_rsp_k, obs_rdata, obs_force, obs_busy_after);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)     begin n_err++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0)     begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_cmp++; if (mem_force !== 1'b0)     begin n_err++; $display("FAIL reset_mem_force got %b exp 0", mem_force); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (sram_cs !== 1'b0)       begin n_err++; $display("FAIL reset_sram_cs got %b exp 0", sram_cs); end
        n_cmp++; if (sram_we !== 1'b0)       begin n_err++; $display("FAIL reset_sram_we got %b exp 0", sram_we); end
        n_cmp++; if (sram_addr !== 16'h0)    begin n_err++; $display("FAIL reset_sram_addr got %h exp 0000", sram_addr); end
        n_cmp++; if (sram_wdata !== 16'h0)   begin n_err++; $display("FAIL reset_sram_wdata got %h exp 0000", sram_wdata); end
        n_cmp++; if (rsp_rdata !== 16'h0)    begin n_err++; $display("FAIL reset_rsp_rdata got %h exp 0000", rsp_rdata); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_load;
        run_word(1'b0, 16'h0010, 16'h0000, 4'd1, 1'b0);
        n_cmp++; if (obs_cs !== 2)              begin n_err++; $display("FAIL load_cs_cycles got %0d exp 2", obs_cs); end
        n_cmp++; if (obs_we !== 0)              begin n_err++; $display("FAIL load_we_cycles got %0d exp 0", obs_we); end
        n_cmp++; if (obs_rsp_k !== 3)           begin n_err++; $display("FAIL load_rsp_cycle got %0d exp 3", obs_rsp_k); end
        n_cmp++; if (obs_rdata !== 16'hBEEF)    begin n_err++; $display("FAIL load_rdata got %h exp beef", obs_rdata); end
        n_cmp++; if (obs_force !== 1'b0)        begin n_err++; $display("FAIL load_force got %b exp 0", obs_force); end
        n_cmp++; if (obs_busy_after !== 1'b0)   begin n_err++; $display("FAIL load_busy_after got %b exp 0", obs_busy_after); end
        n_cmp++; if (obs_rsp_after !== 1'b0)    begin n_err++; $display("FAIL load_rsp_one_cycle got %b exp 0", obs_rsp_after); end
        n_cmp++; if (obs_ready_after !== 1'b1)  begin n_err++; $display("FAIL load_ready_after got %b exp 1", obs_ready_after); end
    endtask

    task automatic test_single_store;
        int wr_before;
        wr_before = wr_count;
        run_word(1'b1, 16'h0020, 16'h1234, 4'd1, 1'b0);
        n_cmp++; if (obs_we !== 2)              begin n_err++; $display("FAIL store_we_cycles got %0d exp 2", obs_we); end
        n_cmp++; if (obs_stable !== 1'b1)       begin n_err++; $display("FAIL store_stable got %b exp 1", obs_stable); end
        n_cmp++; if (obs_rsp_k !== 3)           begin n_err++; $display("FAIL store_rsp_cycle got %0d exp 3", obs_rsp_k); end
        n_cmp++; if (obs_rdata !== 16'hBEEF)    begin n_err++; $display("FAIL store_rdata_held got %h exp beef", obs_rdata); end
        n_cmp++; if (wr_count - wr_before !== 2) begin n_err++; $display("FAIL store_write_count got %0d exp 2", wr_count - wr_before); end
        n_cmp++; if (wr_addr !== 16'h0020 || wr_data !== 16'h1234)
            begin n_err++; $display("FAIL store_write got %h/%h exp 0020/1234", wr_addr, wr_data); end
    endtask

    task automatic test_block_load;
        logic [15:0] exp_rd [3] = '{16'hA0A0, 16'hA1A1, 16'hA2A2};
        logic        exp_fc [3] = '{1'b1, 1'b1, 1'b0};
        for (int w = 0; w < 3; w++) begin
            run_word(1'b0, 16'h0040 + 16'(w), 16'h0000, (w == 0) ? 4'd3 : 4'd7, 1'b0);
            n_cmp++; if (obs_rdata !== exp_rd[w]) begin n_err++; $display("FAIL block_rdata_w%0d got %h exp %h", w, obs_rdata, exp_rd[w]); end
            n_cmp++; if (obs_force !== exp_fc[w]) begin n_err++; $display("FAIL block_force_w%0d got %b exp %b", w, obs_force, exp_fc[w]); end
            n_cmp++; if (obs_busy_after !== exp_fc[w]) begin n_err++; $display("FAIL block_busy_w%0d got %b exp %b", w, obs_busy_after, exp_fc[w]); end
        end
    endtask

    task automatic test_cnt_zero;
        run_word(1'b0, 16'h0042, 16'h0000, 4'd0, 1'b0);
        n_cmp++; if (obs_force !== 1'b0)       begin n_err++; $display("FAIL cnt0_force got %b exp 0", obs_force); end
        n_cmp++; if (obs_busy_after !== 1'b0)  begin n_err++; $display("FAIL cnt0_busy_after got %b exp 0", obs_busy_after); end
        n_cmp++; if (obs_rdata !== 16'hA2A2)   begin n_err++; $display("FAIL cnt0_rdata got %h exp a2a2", obs_rdata); end
    endtask

    task automatic test_back_to_back;
        run_word(1'b0, 16'h0043, 16'h0000, 4'd1, 1'b1);
        n_cmp++; if (obs_rsp_k !== 3)          begin n_err++; $display("FAIL held_rsp_cycle got %0d exp 3", obs_rsp_k); end
        n_cmp++; if (obs_rdata !== 16'hA3A3)   begin n_err++; $display("FAIL held_rdata got %h exp a3a3", obs_rdata); end
        run_word(1'b0, 16'h0010, 16'h0000, 4'd1, 1'b0);
        n_cmp++; if (obs_rdata !== 16'hBEEF)   begin n_err++; $display("FAIL b2b_rdata got %h exp beef", obs_rdata); end
    endtask

    task automatic test_reset_mid_block;
        run_word(1'b0, 16'h0040, 16'h0000, 4'd4, 1'b0);
        n_cmp++; if (obs_busy_after !== 1'b1)  begin n_err++; $display("FAIL rst_blk_busy_w0 got %b exp 1", obs_busy_after); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0041; req_cnt = 4'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (sram_cs !== 1'b1)         begin n_err++; $display("FAIL rst_blk_in_access got %b exp 1", sram_cs); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (sram_cs !== 1'b0)         begin n_err++; $display("FAIL rst_blk_cs got %b exp 0", sram_cs); end
        n_cmp++; if (busy !== 1'b0)            begin n_err++; $display("FAIL rst_blk_busy got %b exp 0", busy); end
        n_cmp++; if (req_ready !== 1'b1)       begin n_err++; $display("FAIL rst_blk_ready got %b exp 1", req_ready); end
        n_cmp++; if (sram_addr !== 16'h0)      begin n_err++; $display("FAIL rst_blk_addr got %h exp 0000", sram_addr); end
        n_cmp++; if (rsp_rdata !== 16'h0)      begin n_err++; $display("FAIL rst_blk_rdata got %h exp 0000", rsp_rdata); end
        @(negedge clk);
        resetn = 1'b1;
        run_word(1'b0, 16'h0041, 16'h0000, 4'd1, 1'b0);
        n_cmp++; if (obs_force !== 1'b0)       begin n_err++; $display("FAIL rst_after_force got %b exp 0", obs_force); end
        n_cmp++; if (obs_busy_after !== 1'b0)  begin n_err++; $display("FAIL rst_after_busy got %b exp 0", obs_busy_after); end
        n_cmp++; if (obs_rdata !== 16'hA1A1)   begin n_err++; $display("FAIL rst_after_rdata got %h exp a1a1", obs_rdata); end
    endtask

    task automatic test_wait_builds;
        int first0, first3, pulses0, pulses3;
        first0 = 0; first3 = 0; pulses0 = 0; pulses3 = 0;
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'h0000; req_cnt = 4'd1;
        req_valid_w0 = 1'b1; req_valid_w3 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_w0) begin pulses0++; if (first0 == 0) first0 = k; end
            if (rsp_w3) begin pulses3++; if (first3 == 0) first3 = k; end
        end
        req_valid_w0 = 1'b0; req_valid_w3 = 1'b0;
        repeat (10) @(negedge clk);
        $display("wait builds: w0 first=%0d pulses=%0d, w3 first=%0d pulses=%0d", first0, pulses0, first3, pulses3);
        n_cmp++; if (first0 !== 2)   begin n_err++; $display("FAIL w0_rsp_cycle got %0d exp 2", first0); end
        n_cmp++; if (first3 !== 5)   begin n_err++; $display("FAIL w3_rsp_cycle got %0d exp 5", first3); end
        n_cmp++; if (pulses0 !== 3)  begin n_err++; $display("FAIL w0_held_pulses got %0d exp 3", pulses0); end
        n_cmp++; if (pulses3 !== 1)  begin n_err++; $display("FAIL w3_held_pulses got %0d exp 1", pulses3); end
        n_cmp++; if (busy_w0 !== 1'b0 || busy_w3 !== 1'b0)
            begin n_err++; $display("FAIL wait_builds_idle got %b%b exp 00", busy_w0, busy_w3); end
    endtask

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_valid_w0 = 1'b0; req_valid_w3 = 1'b0;
        req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000; req_cnt = 4'd0;
        test_reset;
        test_single_load;
        test_single_store;
        test_block_load;
        test_cnt_zero;
        test_back_to_back;
        test_reset_mid_block;
        test_wait_builds;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
